mux_stream_arb: RTL and testbench

//  Parametrised N-channel registered multiplexer with a valid/ready handshake on every input and on the output.

---
 rtl/mux_stream_pkg.sv | 18 +
 rtl/rr_pick.sv | 41 ++++
 rtl/mux_stream_arb.sv | 128 ++++++++++++
 tb/tb_mux_stream_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_stream_pkg.sv
// Purpose : shared constants and helpers for the stream multiplexer/arbiter.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
//
// Contents:
//   MODE_DIRECT / MODE_RR : encodings of the Mode input.
//   clog2Safe()           : $clog2 that never returns 0, so 1-channel
//                           instances still get a 1-bit index.
package mux_stream_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  function automatic int clog2Safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose : rotate-priority picker; first requester after ptr, wrapping.
// Latency : combinational, no state.
// Backpressure : none; the caller decides whether the grant is taken.
//
// Ports:
//   req      in  CHANNELS  request vector
//   ptr      in  SEL_W     last granted channel; search starts at ptr+1
//   gntIdx   out SEL_W     chosen channel (0 when nothing requests)
//   gntValid out 1         at least one request present
module rr_pick
  import mux_stream_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int SEL_W    = clog2Safe(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    gntIdx,
  output logic                gntValid
);

  int idx;

  // Walk the offsets from farthest to nearest so the nearest requester
  // (smallest offset from ptr) is the last write and therefore wins.
  // Offset CHANNELS maps back onto ptr itself, so a lone requester on the
  // previously granted channel is still served.
  always_comb begin
    gntIdx   = '0;
    gntValid = 1'b0;
    idx      = 0;
    for (int k = CHANNELS; k >= 1; k--) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (req[idx[SEL_W-1:0]]) begin
        gntIdx   = idx[SEL_W-1:0];
        gntValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_stream_arb.sv
// Purpose : N-channel registered stream mux, direct (Sel) or round-robin select.
// Latency : exactly 1 cycle from input transfer to output beat; 1 beat/cycle.
// Backpressure : output held while OutReady=0; no InReady until the beat drains.
//
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   Enable              0 blocks new beats; a held output still drains
//   Mode                MODE_DIRECT uses Sel, MODE_RR rotates among valid inputs
//   Sel                 direct-mode channel; out-of-range values never grant
//   InValid/InData      per-channel request and data (channel i at [i*WIDTH +: WIDTH])
//   InReady             one-hot (or zero) acceptance, never depends on InData
//   OutValid/OutData    registered beat; OutData is 0 whenever OutValid is 0
//   OutChan             source channel of the current/last beat
//   OutReady            consumer ready
//   BeatCount           saturating handshake count when MUX_STREAM_BEAT_COUNT_EN
//                       is defined, otherwise tied to 0
module mux_stream_arb
  import mux_stream_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = clog2Safe(CHANNELS)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Enable,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          Sel,
  input  logic [CHANNELS-1:0]       InValid,
  input  logic [CHANNELS*WIDTH-1:0] InData,
  output logic [CHANNELS-1:0]       InReady,
  output logic                      OutValid,
  output logic [WIDTH-1:0]          OutData,
  output logic [SEL_W-1:0]          OutChan,
  input  logic                      OutReady,
  output logic [31:0]               BeatCount
);

  // Index space of Sel; vectors are padded to it so any Sel value is a
  // legal index, and the padding bits are constant zero.
  localparam int PAD = 1 << SEL_W;

  logic [SEL_W-1:0] rrPtr;
  logic [SEL_W-1:0] rrIdx;
  logic             rrValid;
  logic [PAD-1:0]   validPad;
  logic [PAD-1:0]   readyPad;
  logic             directValid;
  logic [SEL_W-1:0] grant;
  logic             grantValid;
  logic             load;
  logic [WIDTH-1:0] selData;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) uPick (
    .req      (InValid),
    .ptr      (rrPtr),
    .gntIdx   (rrIdx),
    .gntValid (rrValid)
  );

  assign validPad    = PAD'(InValid);
  assign directValid = (int'(Sel) < CHANNELS) && validPad[Sel];

  always_comb begin
    grant      = Sel;
    grantValid = directValid;
    if (Mode == MODE_RR) begin
      grant      = rrIdx;
      grantValid = rrValid;
    end
  end

  // Reset gates the load so no InReady pulses while the block is held in reset.
  assign load = !Reset && Enable && grantValid && (!OutValid || OutReady);

  always_comb begin
    readyPad        = '0;
    readyPad[grant] = load;
  end
  assign InReady = readyPad[CHANNELS-1:0];

  // Compare-and-select rather than a variable part-select, so a grant index
  // outside the channel range simply yields zero.
  always_comb begin
    selData = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SEL_W'(i) == grant) selData = InData[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      OutValid <= 1'b0;
      OutData  <= '0;
      OutChan  <= '0;
      rrPtr    <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      OutValid <= 1'b1;
      OutData  <= selData;
      OutChan  <= grant;
      if (Mode == MODE_RR) rrPtr <= grant;
    end else if (OutValid && OutReady) begin
      // Drained with nothing behind it; OutChan keeps the last source.
      OutValid <= 1'b0;
      OutData  <= '0;
    end
  end

`ifdef MUX_STREAM_BEAT_COUNT_EN
  logic [31:0] beatCnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      beatCnt <= '0;
    end else if (OutValid && OutReady && (beatCnt != 32'hFFFF_FFFF)) begin
      beatCnt <= beatCnt + 32'd1;
    end
  end

  assign BeatCount = beatCnt;
`else
  assign BeatCount = 32'h0;
`endif

endmodule

// File: tb/tb_mux_stream_arb.sv
// Purpose : directed bench for mux_stream_arb with a scoreboard monitor.
// Latency : expects every accepted beat on the output one cycle later.
// Backpressure : drives OutReady low/high to exercise stall and drain.
module tb_mux_stream_arb;

  typedef struct packed {
    logic [3:0]  chan;
    logic [31:0] data;
  } beat_t;

  logic          Clock = 1'b0;
  logic          Reset, Enable, Mode, OutReady;
  logic [3:0]    Sel;
  logic [15:0]   InValid, InReady;
  logic [511:0]  InData;
  logic          OutValid;
  logic [31:0]   OutData, BeatCount;
  logic [3:0]    OutChan;

  // Second instance with a non-power-of-two channel count for the Sel range check.
  logic [3:0]    Sel12;
  logic [11:0]   InValid12, InReady12;
  logic [383:0]  InData12;
  logic          OutValid12;
  logic [31:0]   OutData12, BeatCount12;
  logic [3:0]    OutChan12;

  beat_t sbq[$];
  int    nCmp = 0;
  int    nBad = 0;

  always #5 Clock = ~Clock;

  mux_stream_arb #(.WIDTH(32), .CHANNELS(16)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode), .Sel(Sel),
    .InValid(InValid), .InData(InData), .InReady(InReady),
    .OutValid(OutValid), .OutData(OutData), .OutChan(OutChan),
    .OutReady(OutReady), .BeatCount(BeatCount)
  );

  mux_stream_arb #(.WIDTH(32), .CHANNELS(12)) dut12 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode), .Sel(Sel12),
    .InValid(InValid12), .InData(InData12), .InReady(InReady12),
    .OutValid(OutValid12), .OutData(OutData12), .OutChan(OutChan12),
    .OutReady(OutReady), .BeatCount(BeatCount12)
  );

  function automatic logic [31:0] dataOf(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic expectBeat(input int ch, input logic [31:0] d);
    beat_t b;
    b.chan = 4'(ch);
    b.data = d;
    sbq.push_back(b);
  endtask

  task automatic pulseReset();
    Reset   = 1'b1;
    InValid = '0;
    step();
    Reset   = 1'b0;
  endtask

  // Monitor: every output handshake must match the oldest expected beat.
  always @(negedge Clock) begin
    if (Reset === 1'b0 && OutValid === 1'b1 && OutReady === 1'b1) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", {60'd0, OutChan}, 64'hFFFF);
      end else begin
        beat_t b;
        b = sbq.pop_front();
        check("sb_chan", {60'd0, OutChan}, {60'd0, b.chan});
        check("sb_data", {32'd0, OutData}, {32'd0, b.data});
      end
    end
  end

  initial begin
    Reset = 1'b1; Enable = 1'b1; Mode = 1'b0; OutReady = 1'b0;
    Sel = '0; InValid = '0; Sel12 = '0; InValid12 = '0;
    for (int i = 0; i < 16; i++) InData[i*32 +: 32] = dataOf(i);
    for (int i = 0; i < 12; i++) InData12[i*32 +: 32] = dataOf(i + 100);
    step();
    step();
    Reset = 1'b0;
    #1;

    // Reset state
    check("rst_outvalid", {63'd0, OutValid}, 64'd0);
    check("rst_outdata", {32'd0, OutData}, 64'd0);
    check("rst_outchan", {60'd0, OutChan}, 64'd0);
    check("rst_beatcount", {32'd0, BeatCount}, 64'd0);
    check("rst_inready", {48'd0, InReady}, 64'd0);

    // 1: direct, Sel=5
    OutReady = 1'b1; Mode = 1'b0; Sel = 4'd5;
    InData[5*32 +: 32] = 32'hDEAD_BEEF;
    InValid = 16'h0020;
    #1;
    check("t1_inready", {48'd0, InReady}, 64'h0020);
    expectBeat(5, 32'hDEAD_BEEF);
    step();
    InValid = '0;
    check("t1_outvalid", {63'd0, OutValid}, 64'd1);
    check("t1_outdata", {32'd0, OutData}, 64'hDEAD_BEEF);
    check("t1_outchan", {60'd0, OutChan}, 64'd5);
    step();
    check("t1_drain_valid", {63'd0, OutValid}, 64'd0);
    check("t1_drain_data", {32'd0, OutData}, 64'd0);
    check("t1_chan_hold", {60'd0, OutChan}, 64'd5);
    InData[5*32 +: 32] = dataOf(5);

    // 2: RR sweep from reset, 18 beats back to back
    pulseReset();
    Mode = 1'b1; OutReady = 1'b1; InValid = 16'hFFFF;
    for (int k = 0; k < 18; k++) expectBeat(k % 16, dataOf(k % 16));
    for (int k = 0; k < 18; k++) begin
      step();
      check("t2_nogap", {63'd0, OutValid}, 64'd1);
      check("t2_chan", {60'd0, OutChan}, 64'(k % 16));
    end
    InValid = '0;
    step();
    check("t2_end_valid", {63'd0, OutValid}, 64'd0);

    // 3: RR with stall, ch0 held then ch4, ch0
    pulseReset();
    Mode = 1'b1; OutReady = 1'b0; InValid = 16'h0011;
    #1;
    check("t3_first_ready", {48'd0, InReady}, 64'h0001);
    expectBeat(0, dataOf(0));
    step();
    for (int k = 0; k < 3; k++) begin
      check("t3_stall_ready", {48'd0, InReady}, 64'd0);
      check("t3_stall_valid", {63'd0, OutValid}, 64'd1);
      check("t3_stall_chan", {60'd0, OutChan}, 64'd0);
      check("t3_stall_data", {32'd0, OutData}, {32'd0, dataOf(0)});
      step();
    end
    OutReady = 1'b1;
    #1;
    check("t3_release_ready", {48'd0, InReady}, 64'h0010);
    expectBeat(4, dataOf(4));
    expectBeat(0, dataOf(0));
    step();
    check("t3_second_chan", {60'd0, OutChan}, 64'd4);
    step();
    check("t3_third_chan", {60'd0, OutChan}, 64'd0);
    InValid = '0;
    step();
    check("t3_end_valid", {63'd0, OutValid}, 64'd0);

    // 4a: 12-channel instance, Sel out of range / top in range
    Mode = 1'b0; InValid12 = 12'hFFF; Sel12 = 4'd13;
    #1;
    check("t4_sel13_ready", {52'd0, InReady12}, 64'd0);
    step();
    check("t4_sel13_valid", {63'd0, OutValid12}, 64'd0);
    Sel12 = 4'd12;
    #1;
    check("t4_sel12_ready", {52'd0, InReady12}, 64'd0);
    step();
    check("t4_sel12_valid", {63'd0, OutValid12}, 64'd0);
    Sel12 = 4'd11;
    #1;
    check("t4_sel11_ready", {52'd0, InReady12}, 64'h800);
    step();
    InValid12 = '0;
    check("t4_sel11_data", {32'd0, OutData12}, {32'd0, dataOf(111)});
    step();

    // 4b: Enable=0 with a held beat
    Mode = 1'b0; Sel = 4'd3; InValid = 16'h0008; OutReady = 1'b0;
    expectBeat(3, dataOf(3));
    step();
    Enable = 1'b0;
    #1;
    check("t4_dis_ready", {48'd0, InReady}, 64'd0);
    step();
    check("t4_dis_held", {63'd0, OutValid}, 64'd1);
    OutReady = 1'b1;
    #1;
    check("t4_dis_ready_rdy", {48'd0, InReady}, 64'd0);
    step();
    check("t4_dis_drained", {63'd0, OutValid}, 64'd0);
    check("t4_dis_data0", {32'd0, OutData}, 64'd0);
    check("t4_dis_chan", {60'd0, OutChan}, 64'd3);
    InValid = '0; Enable = 1'b1;

    // 5: reset while stalled drops the beat; RR restarts at ch0
    Sel = 4'd2; InValid = 16'h0004; OutReady = 1'b0;
    step();
    check("t5_loaded", {63'd0, OutValid}, 64'd1);
    Reset = 1'b1;
    #1;
    check("t5_rst_ready", {48'd0, InReady}, 64'd0);
    step();
    Reset = 1'b0; InValid = '0;
    check("t5_valid", {63'd0, OutValid}, 64'd0);
    check("t5_data", {32'd0, OutData}, 64'd0);
    check("t5_chan", {60'd0, OutChan}, 64'd0);
    check("t5_count", {32'd0, BeatCount}, 64'd0);
    Mode = 1'b1; OutReady = 1'b1; InValid = 16'hFFFF;
    #1;
    check("t5_rr_ready", {48'd0, InReady}, 64'h0001);
    expectBeat(0, dataOf(0));
    step();
    InValid = '0;
    check("t5_rr_chan", {60'd0, OutChan}, 64'd0);
    step();

    // 6: 99 more handshakes -> 100 since reset
    Mode = 1'b0; Sel = 4'd7; InValid = 16'h0080;
    for (int k = 0; k < 99; k++) expectBeat(7, dataOf(7));
    for (int k = 0; k < 99; k++) step();
    InValid = '0;
    step();
`ifdef MUX_STREAM_BEAT_COUNT_EN
    check("t6_count", {32'd0, BeatCount}, 64'd100);
`else
    check("t6_count", {32'd0, BeatCount}, 64'd0);
`endif
    step();
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
